cursor_position_ctrl: RTL and testbench

Cursor tracker for the 8x8 drawing grid. It turns the four direction buttons into the 6-bit cursor `position` consumed by the two-digit seven-segment decoder and the pixel-write logic. Each press moves the cursor one cell. Holding a button auto-repeats the move.

---
 rtl/cursor_position_ctrl.sv | 128 ++++++++++++
 tb/tb_cursor_position_ctrl.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/cursor_position_ctrl.sv
// rtl/cursor_position_ctrl.sv - 8x8 cursor tracker with button auto-repeat (edge wrap via CURSOR_WRAP_EN)
module cursor_position_ctrl #(
    parameter int HOLD_CYCLES   = 12_500_000,
    parameter int REPEAT_CYCLES = 2_500_000,
    parameter logic [5:0] RESET_POS = 6'd0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       up,
    input  logic       down,
    input  logic       left,
    input  logic       right,
    output logic [5:0] position,
    output logic       moved
);

    localparam int MAX_CYCLES = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
    localparam int CW = $clog2(MAX_CYCLES + 1);
    localparam logic [CW-1:0] HOLD_LAST   = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] REPEAT_LAST = CW'(REPEAT_CYCLES - 1);

    // Direction vector bit order: {up, down, left, right}
    localparam logic [3:0] D_RIGHT = 4'b0001;
    localparam logic [3:0] D_LEFT  = 4'b0010;
    localparam logic [3:0] D_DOWN  = 4'b0100;
    localparam logic [3:0] D_UP    = 4'b1000;

    typedef enum logic [1:0] {IDLE, HOLD, REPEAT} state_t;

    logic [3:0]    sync1;
    logic [3:0]    dir;
    logic [3:0]    held;
    logic [CW-1:0] cnt;
    state_t        state;
    logic          single;
    logic [5:0]    next_pos;

    // Compute the cell reached by one move in direction d; only one field changes
    function automatic logic [5:0] step(input logic [5:0] p, input logic [3:0] d);
        logic [2:0] row;
        logic [2:0] col;
        row = p[5:3];
        col = p[2:0];
`ifdef CURSOR_WRAP_EN
        case (d)
            D_RIGHT: col = col + 3'd1;
            D_LEFT:  col = col - 3'd1;
            D_DOWN:  row = row + 3'd1;
            D_UP:    row = row - 3'd1;
            default: ;
        endcase
`else
        case (d)
            D_RIGHT: if (col != 3'd7) col = col + 3'd1;
            D_LEFT:  if (col != 3'd0) col = col - 3'd1;
            D_DOWN:  if (row != 3'd7) row = row + 3'd1;
            D_UP:    if (row != 3'd0) row = row - 3'd1;
            default: ;
        endcase
`endif
        return {row, col};
    endfunction

    // Two-flop synchronizers for the raw asynchronous buttons
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1 <= 4'd0;
            dir   <= 4'd0;
        end else begin
            sync1 <= {up, down, left, right};
            dir   <= sync1;
        end
    end

    // Exactly one button counts as a direction; none or several are ignored
    assign single   = $onehot(dir);
    assign next_pos = step(position, dir);

    // Press / hold / repeat FSM with registered position and move pulse
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            held     <= 4'd0;
            cnt      <= '0;
            position <= RESET_POS;
            moved    <= 1'b0;
        end else begin
            moved <= 1'b0;
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (single) begin
                        position <= next_pos;
                        moved    <= (next_pos != position);
                        held     <= dir;
                        state    <= HOLD;
                    end
                end
                HOLD, REPEAT: begin
                    if (dir != held) begin
                        // Release or direction change: a pending repeat is dropped
                        cnt <= '0;
                        if (single) begin
                            position <= next_pos;
                            moved    <= (next_pos != position);
                            held     <= dir;
                            state    <= HOLD;
                        end else begin
                            state <= IDLE;
                        end
                    end else if (cnt == ((state == HOLD) ? HOLD_LAST : REPEAT_LAST)) begin
                        cnt      <= '0;
                        position <= next_pos;
                        moved    <= (next_pos != position);
                        state    <= REPEAT;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cursor_position_ctrl.sv
// tb/tb_cursor_position_ctrl.sv - directed table-driven bench for cursor_position_ctrl
module tb_cursor_position_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       up = 1'b0;
    logic       down = 1'b0;
    logic       left = 1'b0;
    logic       right = 1'b0;
    logic [5:0] position;
    logic       moved;

    int tests = 0;
    int fails = 0;
    int mv_cnt = 0;

    cursor_position_ctrl #(
        .HOLD_CYCLES(4),
        .REPEAT_CYCLES(2),
        .RESET_POS(6'd0)
    ) dut (
        .clk(clk),
        .reset(reset),
        .up(up),
        .down(down),
        .left(left),
        .right(right),
        .position(position),
        .moved(moved)
    );

    always #5 clk = ~clk;

    // Count move pulses shortly after each rising edge
    always @(posedge clk) begin
        #1;
        if (moved === 1'b1) mv_cnt++;
    end

    typedef struct {
        logic [3:0] btn;        // {up, down, left, right}
        int         hold;       // edges the raw buttons stay high
        logic [5:0] exp_pos;
        int         exp_moves;
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string name, input int got, input int exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    task automatic drive(input logic [3:0] b);
        {up, down, left, right} = b;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        drive(4'b0000);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    // Hold buttons for k edges, release, then let the pipeline drain
    task automatic press(input logic [3:0] b, input int k, output int moves);
        int start;
        @(negedge clk);
        start = mv_cnt;
        drive(b);
        repeat (k) @(negedge clk);
        drive(4'b0000);
        repeat (6) @(negedge clk);
        moves = mv_cnt - start;
    endtask

    initial begin
        int m;
        int exp_p;
        int start;

        // Moves for a k-edge hold land at offsets 2, 6, 8, 10 ... <= k+1
        vecs[0] = '{4'b0001, 1,  6'd1,  1};
        vecs[1] = '{4'b0001, 1,  6'd2,  1};
        vecs[2] = '{4'b0100, 9,  6'd34, 4};
        vecs[3] = '{4'b0011, 10, 6'd34, 0};
        vecs[4] = '{4'b1100, 10, 6'd34, 0};
        vecs[5] = '{4'b0010, 5,  6'd32, 2};
        vecs[6] = '{4'b1000, 1,  6'd24, 1};
        vecs[7] = '{4'b1010, 6,  6'd24, 0};
        vecs[8] = '{4'b0001, 4,  6'd25, 1};

        // Reset state
        reset = 1'b1;
        repeat (2) @(negedge clk);
        check("reset_pos", position, 0);
        check("reset_moved", moved, 0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // Table of presses from reset position
        for (int i = 0; i < 9; i++) begin
            press(vecs[i].btn, vecs[i].hold, m);
            check($sformatf("vec%0d_pos", i), position, vecs[i].exp_pos);
            check($sformatf("vec%0d_moves", i), m, vecs[i].exp_moves);
        end

        // Auto-repeat timing: hold down from position 2
        do_reset();
        press(4'b0001, 1, m);
        press(4'b0001, 1, m);
        check("ar_start", position, 2);
        @(negedge clk);
        down = 1'b1;
        for (int j = 0; j <= 10; j++) begin
            @(posedge clk);
            #1;
            exp_p = (j < 2) ? 2 : (j < 6) ? 10 : (j < 8) ? 18 : (j < 10) ? 26 : 34;
            check($sformatf("ar_pos_j%0d", j), position, exp_p);
            check($sformatf("ar_moved_j%0d", j), moved, (j == 2 || j == 6 || j == 8 || j == 10) ? 1 : 0);
        end
        @(negedge clk);
        down = 1'b0;
        repeat (6) @(negedge clk);

        // Direction change left -> up mid-hold, starting from 19
        do_reset();
        press(4'b0001, 7, m);
        press(4'b0100, 1, m);
        press(4'b0100, 1, m);
        check("dc_start", position, 19);
        @(negedge clk);
        left = 1'b1;
        repeat (4) @(negedge clk);
        check("dc_left_move", position, 18);
        left = 1'b0;
        up = 1'b1;
        for (int j = 0; j <= 6; j++) begin
            @(posedge clk);
            #1;
            exp_p = (j < 2) ? 18 : (j < 6) ? 10 : 2;
            check($sformatf("dc_pos_j%0d", j), position, exp_p);
        end
        @(negedge clk);
        up = 1'b0;
        repeat (6) @(negedge clk);

        // Asynchronous reset while right is held at position 5
        do_reset();
        @(negedge clk);
        right = 1'b1;
        repeat (13) @(posedge clk);
        #1;
        check("rst_pre_pos", position, 5);
        #3;
        reset = 1'b1;
        #1;
        check("rst_async_pos", position, 0);
        check("rst_async_moved", moved, 0);
        right = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        start = mv_cnt;
        repeat (10) @(negedge clk);
        check("rst_idle_pos", position, 0);
        check("rst_idle_moves", mv_cnt - start, 0);
        press(4'b0001, 1, m);
        check("rst_repress_pos", position, 1);

        // Edge behaviour: right at col 7, up at row 0
        do_reset();
        press(4'b0001, 15, m);
        check("edge_r_start", position, 7);
        press(4'b0001, 1, m);
`ifdef CURSOR_WRAP_EN
        check("edge_r_pos", position, 0);
        check("edge_r_moves", m, 1);
`else
        check("edge_r_pos", position, 7);
        check("edge_r_moves", m, 0);
`endif
        do_reset();
        press(4'b0001, 7, m);
        check("edge_u_start", position, 3);
        press(4'b1000, 1, m);
`ifdef CURSOR_WRAP_EN
        check("edge_u_pos", position, 59);
        check("edge_u_moves", m, 1);
`else
        check("edge_u_pos", position, 3);
        check("edge_u_moves", m, 0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
